// File: rtl/wb_regfile_pkg.sv
// Shared encodings for the write-back stage register file.
// The result-select enum and the fixed register indices live here.
package wb_regfile_pkg;

  typedef enum logic [1:0] {
    RESULT_ALU  = 2'b00,
    RESULT_MEM  = 2'b01,
    RESULT_PC4  = 2'b10,
    RESULT_RSVD = 2'b11
  } result_src_e;

  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// Bundle of write-back, decode-read and observation signals around the register file.
// The master side drives the pipeline inputs; the slave side is the register file.
interface wb_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  logic                  RegWriteW;
  logic [1:0]            ResultSrcW;
  logic [DATA_WIDTH-1:0] ALUResultW;
  logic [DATA_WIDTH-1:0] ReadDataW;
  logic [DATA_WIDTH-1:0] PCPlus4W;
  logic [ADDR_WIDTH-1:0] RdW;
  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [DATA_WIDTH-1:0] RD1;
  logic [DATA_WIDTH-1:0] RD2;
  logic [DATA_WIDTH-1:0] ResultW;
  logic [DATA_WIDTH-1:0] a0;

  modport master (
    output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1, A2,
    input  RD1, RD2, ResultW, a0
  );

  modport slave (
    input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1, A2,
    output RD1, RD2, ResultW, a0
  );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_regfile.sv
// Register storage with one synchronous write port and two combinational read ports.
// x0 is hard-wired to zero; reset clears the whole array and masks every read.
module regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2,
  output logic [DATA_WIDTH-1:0] o_a0
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO = ADDR_WIDTH'(REG_ZERO);
  localparam logic [ADDR_WIDTH-1:0] IDX_A0   = ADDR_WIDTH'(REG_A0);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [ADDR_WIDTH-1:0] w_raddr [2];
  logic [DATA_WIDTH-1:0] w_rdata [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != IDX_ZERO)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign w_raddr[0] = i_raddr1;
  assign w_raddr[1] = i_raddr2;

  // Both read ports are identical; x0 and reset force zero regardless of array contents.
  for (genvar gi = 0; gi < 2; gi++) begin : g_read_port
    assign w_rdata[gi] = (rst || (w_raddr[gi] == IDX_ZERO)) ? '0 : r_regs[w_raddr[gi]];
  end

  assign o_rdata1 = w_rdata[0];
  assign o_rdata2 = w_rdata[1];
  assign o_a0     = rst ? '0 : r_regs[IDX_A0];

endmodule : regfile

// File: rtl/wb_regfile.sv
// Write-back result mux plus register file with same-cycle write-to-read bypass.
// a0 is taken straight from the array so it lags a write by one cycle.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);

  logic [DATA_WIDTH-1:0] w_result;
  logic [DATA_WIDTH-1:0] w_rf_rd1;
  logic [DATA_WIDTH-1:0] w_rf_rd2;
  logic                  w_bypass_en;

  always_comb begin
    w_result = '0;
    case (result_src_e'(bus.ResultSrcW))
      RESULT_ALU: w_result = bus.ALUResultW;
      RESULT_MEM: w_result = bus.ReadDataW;
      RESULT_PC4: w_result = bus.PCPlus4W;
      default:    w_result = '0;
    endcase
  end

  // A write that the array will actually accept is also the condition for forwarding it.
  assign w_bypass_en = bus.RegWriteW && (bus.RdW != ADDR_WIDTH'(REG_ZERO)) && !rst;

  regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (bus.RegWriteW),
    .i_waddr  (bus.RdW),
    .i_wdata  (w_result),
    .i_raddr1 (bus.A1),
    .i_raddr2 (bus.A2),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2),
    .o_a0     (bus.a0)
  );

  assign bus.ResultW = w_result;
  assign bus.RD1     = (w_bypass_en && (bus.A1 == bus.RdW)) ? w_result : w_rf_rd1;
  assign bus.RD2     = (w_bypass_en && (bus.A2 == bus.RdW)) ? w_result : w_rf_rd2;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench: stimulus queues expected outputs, a negedge monitor pops and compares.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam int SEL_RD1 = 0;
  localparam int SEL_RD2 = 1;
  localparam int SEL_RES = 2;
  localparam int SEL_A0  = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t exp_q[$];

  wb_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_out(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  // Drive a new input vector just after the rising edge.
  task automatic drive(input logic r, input logic we, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                       input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst            = r;
    bus.RegWriteW  = we;
    bus.ResultSrcW = src;
    bus.ALUResultW = alu;
    bus.ReadDataW  = mem;
    bus.PCPlus4W   = pc4;
    bus.RdW        = rd;
    bus.A1         = a1;
    bus.A2         = a2;
  endtask

  // Monitor: outputs are combinational, so they are presented every cycle; check at negedge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        SEL_RD1: act = bus.RD1;
        SEL_RD2: act = bus.RD2;
        SEL_RES: act = bus.ResultW;
        default: act = bus.a0;
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%08h", e.name, act);
      end
    end
  end

  initial begin
    int wait_cycles;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.RegWriteW = 1'b0; bus.ResultSrcW = 2'b00;
    bus.ALUResultW = '0; bus.ReadDataW = '0; bus.PCPlus4W = '0;
    bus.RdW = '0; bus.A1 = '0; bus.A2 = '0;

    // Reset cycle 1: reads masked while reset is high.
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd10);
    expect_out("rst_rd1", SEL_RD1, 32'h0);
    expect_out("rst_a0",  SEL_A0,  32'h0);
    // Reset cycle 2 with a pending write to x3: bypass disabled, write suppressed.
    drive(1'b1, 1'b1, 2'b00, 32'h55, 32'h0, 32'h0, 5'd3, 5'd3, 5'd10);
    expect_out("rst_bypass_off", SEL_RD1, 32'h0);
    expect_out("rst_result_comb", SEL_RES, 32'h55);

    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd10);
    expect_out("post_rst_rd1_x5", SEL_RD1, 32'h0);
    expect_out("post_rst_rd2_x10", SEL_RD2, 32'h0);
    expect_out("post_rst_a0", SEL_A0, 32'h0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    expect_out("rst_won_x3", SEL_RD1, 32'h0);

    // Result mux through all four selects.
    for (int s = 0; s < 4; s++) begin
      logic [31:0] m;
      drive(1'b0, 1'b0, 2'(s), 32'h11, 32'h22, 32'h33, 5'd0, 5'd0, 5'd0);
      m = (s == 0) ? 32'h11 : (s == 1) ? 32'h22 : (s == 2) ? 32'h33 : 32'h0;
      expect_out($sformatf("mux_sel%0d", s), SEL_RES, m);
    end

    // Write x10: bypass same cycle, a0 lags by one cycle.
    drive(1'b0, 1'b1, 2'b00, 32'hDEADBEEF, 32'h0, 32'h0, 5'd10, 5'd10, 5'd0);
    expect_out("wr_x10_bypass", SEL_RD1, 32'hDEADBEEF);
    expect_out("wr_x10_a0_lag", SEL_A0, 32'h0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
    expect_out("rd_x10", SEL_RD1, 32'hDEADBEEF);
    expect_out("a0_x10", SEL_A0, 32'hDEADBEEF);

    // Bypass on both ports to x7, then committed value.
    drive(1'b0, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
    expect_out("bypass_rd1_x7", SEL_RD1, 32'h1234);
    expect_out("bypass_rd2_x7", SEL_RD2, 32'h1234);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd10);
    expect_out("rd1_x7", SEL_RD1, 32'h1234);
    expect_out("rd2_x10", SEL_RD2, 32'hDEADBEEF);

    // x0 write discarded, no bypass.
    drive(1'b0, 1'b1, 2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_out("x0_same_cycle", SEL_RD1, 32'h0);
    expect_out("x0_result", SEL_RES, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    expect_out("x0_after", SEL_RD1, 32'h0);

    // Load data into x4, then overwrite with reserved select -> stores zero.
    drive(1'b0, 1'b1, 2'b01, 32'h0, 32'h77, 32'h0, 5'd4, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    expect_out("load_x4", SEL_RD1, 32'h77);
    drive(1'b0, 1'b1, 2'b11, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd4, 5'd0, 5'd4);
    expect_out("rsvd_bypass_x4", SEL_RD2, 32'h0);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd0);
    expect_out("rsvd_stored_x4", SEL_RD1, 32'h0);

    // PC+4 into x1 and overwrite x10; a0 holds old value during the write cycle.
    drive(1'b0, 1'b1, 2'b10, 32'h0, 32'h0, 32'h100, 5'd1, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 2'b00, 32'h5, 32'h0, 32'h0, 5'd10, 5'd1, 5'd0);
    expect_out("pc4_x1", SEL_RD1, 32'h100);
    expect_out("a0_old_during_write", SEL_A0, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd0);
    expect_out("a0_overwrite", SEL_A0, 32'h5);
    expect_out("rd1_x10_overwrite", SEL_RD1, 32'h5);

    // Reset again clears the array.
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd7);
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd10, 5'd7);
    expect_out("rst2_x10", SEL_RD1, 32'h0);
    expect_out("rst2_x7", SEL_RD2, 32'h0);
    expect_out("rst2_a0", SEL_A0, 32'h0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_wb_regfile
